// File: rtl/cpu_pkg.sv
// Shared datapath constants for the multicycle CPU: data width, special register
// addresses, write-destination select encodings and the register-file reset value.
package cpu_pkg;

    localparam int DATA_W = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        REGDST_RT  = 2'b00,
        REGDST_RD  = 2'b01,
        REGDST_RA  = 2'b10,
        REGDST_RSV = 2'b11
    } regdst_e;

    localparam logic [31:0] RF_RST_VAL = 32'h0000_0000;

endpackage

// File: rtl/wa_dec5t32.sv
// Write-address decoder: 5-bit register number to a one-hot write enable,
// fully gated by we so an unknown address with we low enables nothing.
module wa_dec5t32
    import cpu_pkg::*;
(
    input  logic        we,
    input  logic [4:0]  wa,
    output logic [31:0] wen
);

    logic [31:0] wen_s;

    // One-hot decode; register 0 is never enabled
    always_comb begin
        wen_s = 32'h0000_0000;
        if (we && (wa != REG_ZERO)) begin
            wen_s = 32'h0000_0001 << wa;
        end else begin
            wen_s = 32'h0000_0000;
        end
        wen_s[0] = 1'b0;
    end

    assign wen = wen_s;

endmodule

// File: rtl/reg_file_wb.sv
// 32-entry general-purpose register file with two operand read ports, a debug
// read port, optional write-first forwarding and a committed-write counter.
module reg_file_wb
    import cpu_pkg::*;
#(
    parameter int                 DATA_W  = cpu_pkg::DATA_W,
    parameter int                 BYPASS  = 0,
    parameter logic [DATA_W-1:0]  RST_VAL = DATA_W'(RF_RST_VAL)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [4:0]        wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [4:0]        dbg_a,
    output logic [DATA_W-1:0] dbg_d,
    output logic [15:0]       wr_cnt
);

    logic [31:0]       wen_s;
    logic [DATA_W-1:0] regs_r [32];
    logic [15:0]       wr_cnt_r;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;
    logic [DATA_W-1:0] dbg_s;

    wa_dec5t32 u_dec (
        .we  (we),
        .wa  (wa),
        .wen (wen_s)
    );

    // Register storage; entry 0 is held at zero so reads can index it directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= (i == 0) ? '0 : RST_VAL;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wen_s[i]) begin
                    regs_r[i] <= wd;
                end
            end
            regs_r[0] <= '0;
        end
    end

    // Committed-write counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_r <= 16'd0;
        end else if (wen_s != 32'h0000_0000) begin
            wr_cnt_r <= wr_cnt_r + 16'd1;
        end
    end

    // Read port 1 with optional write-first forwarding
    always_comb begin
        rd1_s = '0;
        if (ra1 == REG_ZERO) begin
            rd1_s = '0;
        end else if ((BYPASS != 0) && we && (wa == ra1)) begin
            rd1_s = wd;
        end else begin
            rd1_s = regs_r[ra1];
        end
    end

    // Read port 2 with optional write-first forwarding
    always_comb begin
        rd2_s = '0;
        if (ra2 == REG_ZERO) begin
            rd2_s = '0;
        end else if ((BYPASS != 0) && we && (wa == ra2)) begin
            rd2_s = wd;
        end else begin
            rd2_s = regs_r[ra2];
        end
    end

    // Debug port always shows stored contents, never forwarded data
    always_comb begin
        dbg_s = '0;
        if (dbg_a == REG_ZERO) begin
            dbg_s = '0;
        end else begin
            dbg_s = regs_r[dbg_a];
        end
    end

    assign rd1    = rd1_s;
    assign rd2    = rd2_s;
    assign dbg_d  = dbg_s;
    assign wr_cnt = wr_cnt_r;

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: one instance without and one with forwarding,
// compared against an array-based register model plus directed vectors.
module tb_reg_file_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  dbg_a;
    logic [31:0] rd1_nb, rd2_nb, dbg_nb;
    logic [31:0] rd1_by, rd2_by, dbg_by;
    logic [15:0] cnt_nb, cnt_by;

    logic [31:0] mem [32];
    logic [15:0] cnt;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [31:0] exp_rd;
        logic [15:0] exp_cnt;
    } vec_t;
    vec_t tbl [6];

    always #5 clk = ~clk;

    reg_file_wb #(.BYPASS(0)) u_nb (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
        .dbg_a(dbg_a), .dbg_d(dbg_nb), .wr_cnt(cnt_nb)
    );

    reg_file_wb #(.BYPASS(1)) u_by (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_by), .rd2(rd2_by),
        .dbg_a(dbg_a), .dbg_d(dbg_by), .wr_cnt(cnt_by)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && we && (wa == a)) return wd;
        return mem[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        cnt = 16'd0;
    endtask

    task automatic check_reads();
        chk("nb_rd1", rd1_nb, ref_rd(ra1, 1'b0));
        chk("nb_rd2", rd2_nb, ref_rd(ra2, 1'b0));
        chk("nb_dbg", dbg_nb, ref_rd(dbg_a, 1'b0));
        chk("by_rd1", rd1_by, ref_rd(ra1, 1'b1));
        chk("by_rd2", rd2_by, ref_rd(ra2, 1'b1));
        chk("by_dbg", dbg_by, ref_rd(dbg_a, 1'b0));
    endtask

    // inputs are applied just after a rising edge; reads checked mid-cycle,
    // counter checked just after the next edge
    task automatic cyc(input bit full);
        #2;
        if (full) check_reads();
        @(posedge clk);
        if (rst_n && we && (wa != 5'd0)) begin
            mem[wa] = wd;
            cnt = cnt + 16'd1;
        end
        #1;
        chk("nb_cnt", {16'h0, cnt_nb}, {16'h0, cnt});
        chk("by_cnt", {16'h0, cnt_by}, {16'h0, cnt});
    endtask

    initial begin
        tbl[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  32'hDEAD_BEEF, 16'd1};
        tbl[1] = '{1'b1, 5'd0,  32'h1234_5678, 5'd0,  32'h0000_0000, 16'd1};
        tbl[2] = '{1'b0, 5'd6,  32'hFFFF_FFFF, 5'd6,  32'h0000_0000, 16'd1};
        tbl[3] = '{1'b1, 5'd31, 32'h0040_0004, 5'd31, 32'h0040_0004, 16'd2};
        tbl[4] = '{1'b1, 5'd5,  32'h0000_0001, 5'd5,  32'h0000_0001, 16'd3};
        tbl[5] = '{1'b1, 5'd6,  32'h89AB_CDEF, 5'd5,  32'h0000_0001, 16'd4};

        // reset with a write attempt that must be suppressed
        clear_model();
        rst_n = 1'b0; we = 1'b1; wa = 5'd3; wd = 32'hFFFF_0000;
        ra1 = 5'd3; ra2 = 5'd0; dbg_a = 5'd3;
        repeat (2) cyc(1'b1);
        rst_n = 1'b1; we = 1'b0;
        cyc(1'b1);
        chk("rst_no_write", dbg_nb, 32'h0);

        // directed vectors
        for (int v = 0; v < 6; v++) begin
            we = tbl[v].we; wa = tbl[v].wa; wd = tbl[v].wd;
            cyc(1'b1);
            we = 1'b0; ra1 = tbl[v].ra; ra2 = tbl[v].ra; dbg_a = tbl[v].ra;
            #1;
            chk("vec_rd1", rd1_nb, tbl[v].exp_rd);
            chk("vec_rd2_by", rd2_by, tbl[v].exp_rd);
            chk("vec_dbg", dbg_nb, tbl[v].exp_rd);
            chk("vec_cnt", {16'h0, cnt_nb}, {16'h0, tbl[v].exp_cnt});
        end

        // forwarding on both ports vs old value without forwarding
        #1;
        @(posedge clk); #1;
        we = 1'b1; wa = 5'd31; wd = 32'hCAFE_F00D; ra1 = 5'd31; ra2 = 5'd31; dbg_a = 5'd31;
        #2;
        chk("byp_rd1", rd1_by, 32'hCAFE_F00D);
        chk("byp_rd2", rd2_by, 32'hCAFE_F00D);
        chk("byp_dbg", dbg_by, 32'h0040_0004);
        chk("nobyp_rd1_old", rd1_nb, 32'h0040_0004);
        cyc(1'b1);
        we = 1'b0;
        #1;
        chk("nobyp_rd1_new", rd1_nb, 32'hCAFE_F00D);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom); wd = $urandom;
            ra1 = 5'($urandom); ra2 = 5'($urandom); dbg_a = 5'($urandom);
            if ($urandom_range(0, 3) == 0) ra1 = wa;
            if ($urandom_range(0, 3) == 0) ra2 = wa;
            if ($urandom_range(0, 7) == 0) dbg_a = wa;
            cyc(1'b1);
        end

        // asynchronous reset mid-cycle: contents clear without a clock edge
        we = 1'b0;
        #2;
        rst_n = 1'b0;
        clear_model();
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i); dbg_a = 5'(i);
            #1;
            check_reads();
        end
        chk("rst_cnt", {16'h0, cnt_nb}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // reset asserted across a write edge: write lost
        we = 1'b1; wa = 5'd7; wd = 32'h1111_1111;
        cyc(1'b1);
        wd = 32'hA5A5_A5A5;
        #3;
        rst_n = 1'b0;
        clear_model();
        @(posedge clk); #1;
        we = 1'b0; rst_n = 1'b1; ra1 = 5'd7; ra2 = 5'd7; dbg_a = 5'd7;
        #1;
        chk("rstwr_rd1", rd1_nb, 32'h0);
        chk("rstwr_dbg", dbg_by, 32'h0);
        chk("rstwr_cnt", {16'h0, cnt_by}, 32'h0);

        // counter wrap and decoder aliasing sweep
        @(posedge clk); #1;
        for (int n = 0; n < 65536; n++) begin
            we = 1'b1; wa = 5'((n % 31) + 1); wd = 32'((n % 31) + 1);
            cyc(1'b0);
            if (n == 65534) chk("cnt_max", {16'h0, cnt_nb}, 32'h0000_FFFF);
        end
        chk("cnt_wrap", {16'h0, cnt_nb}, 32'h0);
        chk("cnt_wrap_by", {16'h0, cnt_by}, 32'h0);
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(i); dbg_a = 5'(i);
            #1;
            chk("own_idx_dbg", dbg_nb, 32'(i));
            chk("own_idx_rd1", rd1_by, 32'(i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 32 x 32-bit general-purpose register file for the multicycle CPU datapath.
- Consumes the 5-bit write-register address produced by the write-destination select (rt / rd / $31 / spare). It decodes that address into one-hot write enables and stores the write-back data.
- Supplies two combinational read ports to the operand A/B latches, plus a debug read port for the board display.
- Register 0 is hard-wired to zero.

Parameters:
- DATA_W, 32, register width in bits.
- BYPASS, 0, 1 = a same-cycle write is forwarded to any read port addressing the same register (write-first); 0 = reads return the stored value only.
- RST_VAL, 32'h0000_0000, value loaded into registers 1..31 on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  write enable from the control FSM (RegWrite).
- wa  in  5  write register address (output of the write-destination select).
- wd  in  DATA_W  write-back data (ALUOut / MDR / PC+4, already selected).
- ra1  in  5  read address, port 1 (rs).
- ra2  in  5  read address, port 2 (rt).
- rd1  out  DATA_W  read data, port 1.
- rd2  out  DATA_W  read data, port 2.
- dbg_a  in  5  debug read address.
- dbg_d  out  DATA_W  debug read data (never bypassed).
- wr_cnt  out  16  count of committed writes, for bench and display.

Behaviour:
- Reset:
  - rst_n low asynchronously forces registers 1..31 to RST_VAL and wr_cnt to 0, independent of clk.
  - While rst_n is low, writes are suppressed and wr_cnt holds 0.
  - Release is sampled at the next rising edge; the first write can commit on the first edge with rst_n high.
  - Outputs during reset follow the read rules on the reset contents. rd1, rd2 and dbg_d are 0 when addressing register 0.
- Write:
  - On a rising edge with we=1 and wa!=0, reg[wa] <= wd and wr_cnt increments by 1.
  - wr_cnt wraps 16'hFFFF -> 0.
  - we=1 with wa=0 is a legal no-op: nothing is stored and wr_cnt does not increment.
  - we=0: nothing changes.
- Write decode:
  - 5-to-32 one-hot enable, gated by we.
  - Bit 0 of the enable is forced to 0.
  - At most one register is written per edge.
- Read:
  - Fully combinational; zero-cycle latency from ra1/ra2/dbg_a.
  - Address 0 always returns 0, regardless of any write.
- Bypass, when BYPASS=1:
  - If we=1, wa!=0 and wa==ra1, then rd1 = wd in the same cycle. Same rule for ra2 / rd2.
  - Both ports may bypass at once when ra1==ra2==wa.
  - dbg_d never bypasses.
- No bypass, when BYPASS=0:
  - A read of wa in the write cycle returns the old value.
  - The new value is visible after the edge.
- Simultaneous events:
  - Reset asserted on a write edge: reset wins and the write is lost.
  - X on wa with we=0 must not corrupt state. The decoder output is fully gated by we.
- No handshake: the control FSM guarantees we is a single-cycle pulse per write-back state.
- Width rules:
  - wd is stored unmodified.
  - The address is 5 bits, so no out-of-range case exists.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W.
  - REG_ZERO = 5'd0.
  - REG_RA = 5'd31.
  - RegDst encodings: 2'b00 rt, 2'b01 rd, 2'b10 $31, 2'b11 reserved.
  - Register-file reset constant.
- One sub-module is natural: wa_dec5t32 (inputs we and wa[4:0], output 32-bit one-hot with bit 0 forced low). It is instantiated once.
- Storage, read muxes, bypass and counter stay in reg_file_wb.

Test Plan:
- Reset: pulse rst_n low mid-cycle with RST_VAL=0 -> all rd1/rd2/dbg_d read 0 immediately, without waiting for a clock edge; wr_cnt=0.
- Basic write/read: we=1, wa=5, wd=32'hDEADBEEF, one edge -> ra1=5 gives rd1=32'hDEADBEEF; wr_cnt=1.
- Zero register: we=1, wa=0, wd=32'h12345678 -> rd1 with ra1=0 is 0; wr_cnt unchanged.
- Bypass: BYPASS=1, we=1, wa=31, wd=32'h00400004, ra1=ra2=31 -> rd1=rd2=32'h00400004 before the edge. BYPASS=0 -> old value before the edge, new value after.
- Reset during write: rst_n falls while we=1, wa=7, wd=32'hA5A5A5A5 at the edge -> reg7 reads RST_VAL after release; wr_cnt=0.
- Counter and one-hot decode: write 1..31 with wd=index, loop until wr_cnt wraps 65535->0 -> wrap observed at wr_cnt 0. Every register reads back its own index, proving no aliasing in the decoder.
